// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - shared constants and state type for the QPP turbo (de)interleaver
package turbo_pkg;

  localparam int QPP_KMAX = 6144;
  localparam int QPP_AW   = 13;

  localparam int K_SMALL  = 1056;
  localparam int K_LARGE  = 6144;
  localparam int F1_SMALL = 17;
  localparam int F2_SMALL = 66;
  localparam int F1_LARGE = 263;
  localparam int F2_LARGE = 480;

  // Second difference of pi(i): 2*f2 mod K (132 and 960)
  localparam int D2_SMALL = (2 * F2_SMALL) % K_SMALL;
  localparam int D2_LARGE = (2 * F2_LARGE) % K_LARGE;

  typedef enum logic [1:0] {
    S_RECV,
    S_SCATTER,
    S_SEND
  } state_t;

endpackage

// File: rtl/qpp_addr_gen.sv
// rtl/qpp_addr_gen.sv - recursive QPP address generator, pi(i+1)=pi(i)+g(i), g(i+1)=g(i)+2*f2
module qpp_addr_gen
  import turbo_pkg::*;
#(
  parameter int AW = QPP_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          step,
  input  logic          cbs_latched,
  output logic [AW-1:0] pi
);

  logic [AW-1:0] g;
  logic [AW-1:0] k;
  logic [AW-1:0] g_init;
  logic [AW-1:0] d2;

  // Both operands are already reduced, so one conditional subtract suffices
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] m);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[AW-1:0];
  endfunction

  assign k      = cbs_latched ? AW'(K_LARGE) : AW'(K_SMALL);
  assign g_init = cbs_latched ? AW'(F1_LARGE + F2_LARGE) : AW'(F1_SMALL + F2_SMALL);
  assign d2     = cbs_latched ? AW'(D2_LARGE) : AW'(D2_SMALL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pi <= '0;
      g  <= AW'(F1_SMALL + F2_SMALL);
    end else if (init) begin
      pi <= '0;
      g  <= g_init;
    end else if (step) begin
      pi <= mod_add(pi, g, k);
      g  <= mod_add(g, d2, k);
    end
  end

endmodule

// File: rtl/turbo_deinterleaver.sv
// rtl/turbo_deinterleaver.sv - QPP turbo deinterleaver: scatter bits to pi(i), stream out in natural order
module turbo_deinterleaver
  import turbo_pkg::*;
#(
  parameter int KMAX = QPP_KMAX,
  parameter int AW   = QPP_AW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vld_in,
  output logic       rdy_in,
  input  logic       cbs,
  input  logic [7:0] data_in,
  output logic       vld_out,
  input  logic       rdy_out,
  output logic [7:0] data_out,
  output logic       last_byte
);

  state_t          state, state_nxt;
  logic [KMAX-1:0] mem;
  logic [AW-1:0]   bit_cnt, bit_cnt_inc, k_cur, pi;
  logic [AW-4:0]   oidx, oidx_inc, oidx_last;
  logic [7:0]      shift;
  logic            cbs_q, cbs_sel, first_byte, byte_done, block_full;

  assign first_byte  = (bit_cnt == '0);
  // The first byte of a block must see the live cbs, since cbs_q is updated on that same edge
  assign cbs_sel     = (state == S_RECV && first_byte) ? cbs : cbs_q;
  assign k_cur       = cbs_q ? AW'(K_LARGE) : AW'(K_SMALL);
  assign oidx_last   = cbs_q ? (AW-3)'(K_LARGE / 8 - 1) : (AW-3)'(K_SMALL / 8 - 1);
  assign bit_cnt_inc = bit_cnt + AW'(1);
  assign oidx_inc    = oidx + (AW-3)'(1);
  assign byte_done   = (bit_cnt[2:0] == 3'd7);
  assign block_full  = (bit_cnt_inc == k_cur);

  qpp_addr_gen #(.AW(AW)) u_addr (
    .clk         (clk),
    .reset       (reset),
    .init        (state == S_RECV && vld_in && first_byte),
    .step        (state == S_SCATTER),
    .cbs_latched (cbs_sel),
    .pi          (pi)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RECV;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy_in    = 1'b0;
    case (state)
      S_RECV: begin
        rdy_in = 1'b1;
        if (vld_in) state_nxt = S_SCATTER;
      end
      S_SCATTER: if (byte_done) state_nxt = block_full ? S_SEND : S_RECV;
      S_SEND:    if (vld_out && rdy_out && last_byte) state_nxt = S_RECV;
      default:   state_nxt = S_RECV;
    endcase
  end

  // Bit storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (state == S_SCATTER) mem[pi] <= shift[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cbs_q     <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      oidx      <= '0;
      vld_out   <= 1'b0;
      last_byte <= 1'b0;
      data_out  <= '0;
    end else begin
      case (state)
        S_RECV: begin
          if (vld_in) begin
            shift <= data_in;
            if (first_byte) cbs_q <= cbs;
          end
        end
        S_SCATTER: begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt_inc;
          if (byte_done) oidx <= '0;
        end
        S_SEND: begin
          // Output is registered: the first cycle in S_SEND only fetches byte 0
          if (!vld_out) begin
            vld_out   <= 1'b1;
            data_out  <= mem[{oidx, 3'b000} +: 8];
            last_byte <= (oidx == oidx_last);
          end else if (rdy_out) begin
            if (last_byte) begin
              vld_out   <= 1'b0;
              last_byte <= 1'b0;
              bit_cnt   <= '0;
            end else begin
              oidx      <= oidx_inc;
              data_out  <= mem[{oidx_inc, 3'b000} +: 8];
              last_byte <= (oidx_inc == oidx_last);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// tb/tb_turbo_deinterleaver.sv - self-checking bench for turbo_deinterleaver
module tb_turbo_deinterleaver;

  logic       clk = 1'b0;
  logic       reset, vld_in, rdy_in, cbs, vld_out, rdy_out, last_byte;
  logic [7:0] data_in, data_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int out_idx = 0;

  logic [7:0] exp_q[$];
  bit         exp_l[$];
  logic [7:0] got[$];
  int         acc_cyc[$];
  bit         blk[6144];
  bit         orig[6144];
  bit         nat[6144];

  turbo_deinterleaver dut (
    .clk       (clk),
    .reset     (reset),
    .vld_in    (vld_in),
    .rdy_in    (rdy_in),
    .cbs       (cbs),
    .data_in   (data_in),
    .vld_out   (vld_out),
    .rdy_out   (rdy_out),
    .data_out  (data_out),
    .last_byte (last_byte)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output scoreboard: every accepted output byte is checked against the model queue
  always @(negedge clk) begin
    if (vld_out && rdy_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output data=%h last=%b required=none", data_out, last_byte);
      end else begin
        logic [7:0] eb;
        bit el;
        eb = exp_q.pop_front();
        el = exp_l.pop_front();
        if (data_out !== eb || last_byte !== el) begin
          failures++;
          $display("FAIL out_byte idx=%0d data=%h last=%b required data=%h last=%b",
                   out_idx, data_out, last_byte, eb, el);
        end
        got.push_back(data_out);
        out_idx++;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int qpp(input int i, input int k);
    longint f1, f2, li;
    f1 = (k == 1056) ? 17 : 263;
    f2 = (k == 1056) ? 66 : 480;
    li = i;
    return int'((f1 * li + f2 * li * li) % k);
  endfunction

  task automatic new_block();
    exp_q.delete();
    exp_l.delete();
    got.delete();
    acc_cyc.delete();
    out_idx = 0;
  endtask

  task automatic push_nat(input int k);
    logic [7:0] b;
    for (int j = 0; j < k / 8; j++) begin
      for (int x = 0; x < 8; x++) b[x] = nat[8*j+x];
      exp_q.push_back(b);
      exp_l.push_back(j == k / 8 - 1);
    end
  endtask

  task automatic model_scatter(input int k);
    for (int i = 0; i < k; i++) nat[qpp(i, k)] = blk[i];
    push_nat(k);
  endtask

  task automatic model_roundtrip(input int k);
    for (int i = 0; i < k; i++) begin
      blk[i] = orig[qpp(i, k)];
      nat[i] = orig[i];
    end
    push_nat(k);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic c);
    int n;
    n = 0;
    data_in = b;
    cbs     = c;
    vld_in  = 1'b1;
    @(negedge clk);
    while (!rdy_in && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("FAIL send_timeout rdy_in=%b required=1", rdy_in);
    end
    @(posedge clk);
    #1;
    acc_cyc.push_back(cyc);
  endtask

  task automatic send_block(input int k, input bit big, input bit toggle, input int nbytes);
    logic [7:0] b;
    logic       c;
    for (int j = 0; j < nbytes; j++) begin
      for (int x = 0; x < 8; x++) b[x] = blk[8*j+x];
      c = (toggle && j > 0) ? ((j % 2) == 1) : big;
      send_byte(b, c);
    end
    vld_in = 1'b0;
  endtask

  task automatic check_latency();
    int n;
    n = 0;
    while (!vld_out && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", n, 9);
    chk("rdy_in_in_send", rdy_in, 0);
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("out_count", out_idx, k / 8);
    chk("vld_out_idle", vld_out, 0);
    chk("rdy_in_idle", rdy_in, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 6144; i++) blk[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_single(input int pos);
    for (int i = 0; i < 6144; i++) blk[i] = 1'b0;
    blk[pos] = 1'b1;
  endtask

  initial begin
    int         n;
    int         gv;
    logic [7:0] held, req4;

    reset   = 1'b0;
    vld_in  = 1'b0;
    data_in = 8'h00;
    cbs     = 1'b0;
    rdy_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy_in", rdy_in, 1);
    chk("reset_vld_out", vld_out, 0);
    chk("reset_last_byte", last_byte, 0);
    chk("reset_data_out", data_out, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // K=1056 single bit at stream index 1
    new_block();
    fill_single(1);
    model_scatter(1056);
    chk("model_pi1_small", qpp(1, 1056), 83);
    chk("model_small_byte10", exp_q[10], 8'h08);
    send_block(1056, 1'b0, 1'b0, 132);
    check_latency();
    drain(1056);
    gv = (got.size() > 10) ? int'(got[10]) : -1;
    chk("dut_small_byte10", gv, 8'h08);
    gv = (got.size() > 131) ? int'(got[131]) : -1;
    chk("dut_small_byte131", gv, 8'h00);

    // K=6144 single bit at stream index 1
    new_block();
    fill_single(1);
    model_scatter(6144);
    chk("model_pi1_large", qpp(1, 6144), 743);
    chk("model_large_byte92", exp_q[92], 8'h80);
    send_block(6144, 1'b1, 1'b0, 768);
    check_latency();
    drain(6144);
    gv = (got.size() > 92) ? int'(got[92]) : -1;
    chk("dut_large_byte92", gv, 8'h80);
    gv = (got.size() > 91) ? int'(got[91]) : -1;
    chk("dut_large_byte91", gv, 8'h00);

    // Round trip of a random vector with backpressure at output byte 4
    new_block();
    for (int i = 0; i < 6144; i++) orig[i] = 1'($urandom_range(0, 1));
    model_roundtrip(1056);
    for (int x = 0; x < 8; x++) req4[x] = orig[32+x];
    send_block(1056, 1'b0, 1'b0, 132);
    n = 0;
    while (!(vld_out && out_idx == 4) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_reach_byte4", n < 200, 1);
    rdy_out = 1'b0;
    held = data_out;
    chk("bp_byte4_value", held, req4);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", data_out, held);
      chk("bp_hold_vld", vld_out, 1);
    end
    rdy_out = 1'b1;
    drain(1056);

    // Reset in the middle of receiving, then a fresh block
    new_block();
    fill_random();
    send_block(1056, 1'b0, 1'b0, 50);
    chk("pre_reset_rdy_in", rdy_in, 0);
    reset = 1'b0;
    #1;
    chk("midreset_rdy_in", rdy_in, 1);
    chk("midreset_vld_out", vld_out, 0);
    chk("midreset_last_byte", last_byte, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    new_block();
    fill_random();
    model_scatter(1056);
    send_block(1056, 1'b0, 1'b0, 132);
    drain(1056);

    // vld_in held high throughout, cbs toggling after the first byte
    new_block();
    fill_random();
    model_scatter(1056);
    send_block(1056, 1'b0, 1'b1, 132);
    for (int j = 1; j < 6; j++) chk("accept_gap", acc_cyc[j] - acc_cyc[j-1], 9);
    drain(1056);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turbo_deinterleaver.md
Name: turbo_deinterleaver

Overview:
- Inverse of the LTE QPP turbo interleaver. Accepts one code block of interleaved bits as bytes and returns the same block in natural order as bytes.
- Sits on the decoder side of the turbo chain, after the turbo decoder output and before CRC check.
- Bit i of the input stream is c'(i) = c(pi(i)), where pi(i) = (f1*i + f2*i*i) mod K. The block writes c'(i) into position pi(i), then reads positions 0..K-1 in order.

Parameters:
- KMAX, 6144, size of the bit storage array (largest supported block).
- AW, 13, address width for bit indices and QPP arithmetic.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- vld_in  in  1  input byte valid.
- rdy_in  out  1  block can accept a byte this cycle.
- cbs  in  1  code block size: 0 -> K=1056 (f1=17, f2=66); 1 -> K=6144 (f1=263, f2=480). Sampled only on the first byte of a block.
- data_in  in  8  interleaved bits; bit b of byte j is stream index 8j+b (LSB first).
- vld_out  out  1  output byte valid.
- rdy_out  in  1  downstream ready.
- data_out  out  8  natural-order bits; bit b of byte j is c(8j+b).
- last_byte  out  1  high with the final output byte of the block (byte K/8-1).

Behaviour:
- Handshakes: a transfer occurs at a rising edge where vld and rdy are both high.
- States:
  - S_RECV: rdy_in=1.
  - S_SCATTER: rdy_in=0; runs 8 cycles.
  - S_SEND: vld_out=1.
- Reset (reset low, asynchronous):
  - state=S_RECV, so rdy_in=1.
  - vld_out=0, last_byte=0, data_out=8'h00.
  - Bit counter=0, pi=0, g=f1+f2 of the default K.
  - The bit array is not reset.
- S_RECV:
  - On an input transfer, load data_in into an 8-bit shift register and go to S_SCATTER.
  - If the bit counter is 0, also latch cbs into the block K/f1/f2 selection and initialise pi=0, g=(f1+f2) mod K.
- S_SCATTER, one bit per cycle for 8 cycles:
  - mem[pi] <= shift[0]; shift right by 1.
  - pi <= (pi+g) mod K; g <= (g + 2*f2) mod K, where 2*f2 mod K is 132 for K=1056 and 960 for K=6144.
  - Bit counter increments.
  - After the 8th bit: if bit counter == K, go to S_SEND with output byte index 0; else go to S_RECV.
- Modular add: both operands are < K, so compute sum = a+b (AW+1 bits) and subtract K if sum >= K. No multipliers.
- S_SEND:
  - data_out = mem[8*oidx +: 8]; last_byte = (oidx == K/8-1); 132 output bytes for K=1056, 768 for K=6144.
  - On an output transfer oidx increments.
  - On the transfer with last_byte=1: go to S_RECV, clear bit counter, vld_out=0.
- Latency: vld_out rises on the 9th rising edge after the edge that accepts the block's final input byte.
- Backpressure: while rdy_out=0, vld_out, data_out and last_byte hold stable. No input is accepted in S_SEND, so rdy_in=0 there.
- vld_in high while rdy_in=0 is ignored. Data is not captured.
- Reset mid-block, in any state: the partial block is discarded and the block returns to reset values within the same cycle (asynchronous).
- cbs changes mid-block are ignored until the next block's first byte.

Decomposition:
- Shared package turbo_pkg holds:
  - Constants K_SMALL=1056, K_LARGE=6144, F1_SMALL=17, F2_SMALL=66, F1_LARGE=263, F2_LARGE=480.
  - Precomputed 2*f2 mod K values (132, 960).
  - State enum for S_RECV/S_SCATTER/S_SEND.
- Sub-module qpp_addr_gen, reused later by the interleaver rewrite:
  - Inputs: clk, reset, init, step, cbs_latched.
  - Output: pi[AW-1:0].
  - Implements the recursive pi/g update with modular adds.

Test Plan:
- K=1056, cbs=0, byte 0 = 8'h02 (stream bit 1 = 1), other 131 bytes 8'h00, rdy_out=1 -> pi(1)=83, so output byte 10 = 8'h08, all others 8'h00; last_byte only on byte 131; vld_out rises 9 cycles after the last input edge.
- K=6144, cbs=1, byte 0 = 8'h02, rest zero -> pi(1)=743, so output byte 92 = 8'h80, others 0; exactly 768 output bytes.
- Round trip: the 1056-bit vector through the existing interleaver, then through turbo_deinterleaver -> output bits equal the original vector bit-for-bit.
- Backpressure: drop rdy_out for 2 cycles at output byte 4 -> data_out holds byte 4 unchanged, no byte is skipped or duplicated, total 132 transfers.
- Reset mid-block: assert reset after 50 input bytes -> rdy_in=1 and vld_out=0 immediately; a fresh K=1056 block then produces correct output with no stale bits.
- Protocol: hold vld_in=1 continuously -> exactly one byte is accepted per 9 cycles (rdy_in low during S_SCATTER); cbs toggled after byte 0 has no effect.
